// File: rtl/stream_packer_pkg.sv
// rtl/stream_packer_pkg.sv - shared types and derived widths for the stream packer
// Purpose: FSM state encoding plus default parameters and the widths derived from them.
// Ports:   none (package).
package stream_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam int DEF_BW    = 8;
    localparam int DEF_NPACK = 4;
    localparam int DEF_LW    = 8;

    // Widths for the default configuration.
    localparam int DEF_LANE_W = (DEF_NPACK > 1) ? $clog2(DEF_NPACK) : 1;
    localparam int DEF_OUT_W  = DEF_NPACK * DEF_BW;

    // Lane-index width for an arbitrary lane count; a single lane still needs one bit.
    function automatic int lane_idx_w(input int npack);
        return (npack > 1) ? $clog2(npack) : 1;
    endfunction

endpackage

// File: rtl/stream_packer.sv
// rtl/stream_packer.sv - packs narrow FIFO words into masked wide beats per packet
// Purpose: accepts a packet length on the cfg channel, consumes that many BW-bit
//          words from src, and emits NPACK-lane beats (LSB lane first) on dst.
// Ports:   i_clk, i_rst (async, active-low)
//          cfg_rdy/cfg_ack/i_cfg_len : packet descriptor channel
//          src_rdy/src_ack/i_data    : narrow input word channel
//          dst_rdy/dst_ack           : wide output beat channel
//          o_data/o_mask/o_last      : beat payload, lane-valid mask, last-beat flag
module stream_packer
    import stream_packer_pkg::*;
#(
    parameter int BW    = DEF_BW,
    parameter int NPACK = DEF_NPACK,
    parameter int LW    = DEF_LW
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                cfg_rdy,
    output logic                cfg_ack,
    input  logic [LW-1:0]       i_cfg_len,
    input  logic                src_rdy,
    output logic                src_ack,
    input  logic [BW-1:0]       i_data,
    output logic                dst_rdy,
    input  logic                dst_ack,
    output logic [NPACK*BW-1:0] o_data,
    output logic [NPACK-1:0]    o_mask,
    output logic                o_last
);

    localparam int LANE_W = lane_idx_w(NPACK);

    state_t             r_state;
    logic [LW-1:0]      r_rem;
    logic [LANE_W-1:0]  r_lane;
    logic [NPACK-1:0]   r_mask;
    logic               r_last;
    logic [BW-1:0]      r_lanes [NPACK];

    logic [NPACK-1:0]   w_lane_en;
    logic               w_lane_clr;

    // The only combinational input-to-output paths: acks gated by state.
    assign cfg_ack = (r_state == ST_IDLE) && cfg_rdy;
    assign src_ack = (r_state == ST_PACK) && src_rdy;
    assign dst_rdy = (r_state == ST_OUT);
    assign o_mask  = r_mask;
    assign o_last  = r_last;

    // Lanes clear when a new packet starts or when a non-final beat is handed off,
    // so a partial final beat always shows zeros in its unused lanes.
    assign w_lane_clr = (cfg_ack && (i_cfg_len != '0)) ||
                        ((r_state == ST_OUT) && dst_ack && !r_last);

    always_comb begin
        w_lane_en = '0;
        for (int k = 0; k < NPACK; k++) begin
            w_lane_en[k] = src_ack && (r_lane == LANE_W'(k));
        end
    end

    // Lane storage: each lane only loads when it is the write target.
    for (genvar k = 0; k < NPACK; k++) begin : g_lane
        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_lanes[k] <= '0;
            end else if (w_lane_clr) begin
                r_lanes[k] <= '0;
            end else if (w_lane_en[k]) begin
                r_lanes[k] <= i_data;
            end
        end
        assign o_data[k*BW +: BW] = r_lanes[k];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_lane  <= '0;
            r_mask  <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Zero-length descriptors are accepted and silently dropped.
                    if (cfg_rdy && (i_cfg_len != '0)) begin
                        r_rem   <= i_cfg_len;
                        r_lane  <= '0;
                        r_mask  <= '0;
                        r_last  <= 1'b0;
                        r_state <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (src_rdy) begin
                        r_mask[r_lane] <= 1'b1;
                        r_rem          <= r_rem - LW'(1);
                        r_lane         <= r_lane + LANE_W'(1);
                        if (r_rem == LW'(1)) begin
                            r_last  <= 1'b1;
                            r_state <= ST_OUT;
                        end else if (r_lane == LANE_W'(NPACK - 1)) begin
                            r_state <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (dst_ack) begin
                        if (r_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_lane  <= '0;
                            r_mask  <= '0;
                            r_state <= ST_PACK;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// tb/tb_stream_packer.sv - self-checking bench for stream_packer
module tb_stream_packer;

    localparam int BW    = 8;
    localparam int NPACK = 4;
    localparam int LW    = 8;
    localparam int OW    = NPACK * BW;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              cfg_rdy = 1'b0;
    logic              cfg_ack;
    logic [LW-1:0]     i_cfg_len = '0;
    logic              src_rdy = 1'b0;
    logic              src_ack;
    logic [BW-1:0]     i_data = '0;
    logic              dst_rdy;
    logic              dst_ack = 1'b0;
    logic [OW-1:0]     o_data;
    logic [NPACK-1:0]  o_mask;
    logic              o_last;

    stream_packer #(.BW(BW), .NPACK(NPACK), .LW(LW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .cfg_rdy(cfg_rdy), .cfg_ack(cfg_ack), .i_cfg_len(i_cfg_len),
        .src_rdy(src_rdy), .src_ack(src_ack), .i_data(i_data),
        .dst_rdy(dst_rdy), .dst_ack(dst_ack),
        .o_data(o_data), .o_mask(o_mask), .o_last(o_last)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Driver controls and traffic queues.
    bit               drv_en = 1'b0;
    bit               src_toggle = 1'b0;
    int               src_stall_pct = 0;
    int               dst_stall_pct = 0;
    int               dst_hold = 0;
    int               words_taken = 0;
    logic [BW-1:0]    src_q[$];
    logic [OW-1:0]    cap_d[$];
    logic [NPACK-1:0] cap_m[$];
    logic             cap_l[$];
    logic [OW-1:0]    exp_d[$];
    logic [NPACK-1:0] exp_m[$];
    logic             exp_l[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: a packet's words split into NPACK-sized chunks, lane 0 first.
    task automatic model_packet(input logic [BW-1:0] w[$]);
        logic [OW-1:0]    d;
        logic [NPACK-1:0] m;
        for (int i = 0; i < w.size(); i += NPACK) begin
            d = '0;
            m = '0;
            for (int k = 0; k < NPACK && i + k < w.size(); k++) begin
                d = d | (OW'(w[i + k]) << (k * BW));
                m[k] = 1'b1;
            end
            exp_d.push_back(d);
            exp_m.push_back(m);
            exp_l.push_back(i + NPACK >= w.size());
        end
    endtask

    task automatic clear_caps();
        cap_d.delete(); cap_m.delete(); cap_l.delete();
        exp_d.delete(); exp_m.delete(); exp_l.delete();
    endtask

    // Source: presents queued words, keeps rdy/data steady until acked.
    initial begin
        bit holding;
        bit tog;
        bit go;
        holding = 1'b0;
        tog = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!drv_en || src_q.size() == 0) begin
                src_rdy = 1'b0;
                holding = 1'b0;
            end else if (holding) begin
                src_rdy = 1'b1;
                i_data  = src_q[0];
            end else begin
                go = 1'b1;
                if (src_toggle) begin
                    tog = ~tog;
                    go  = tog;
                end
                if (src_stall_pct > 0 && $urandom_range(99) < src_stall_pct) go = 1'b0;
                src_rdy = go;
                i_data  = go ? src_q[0] : BW'($urandom);
            end
            #1;
            if (src_ack) chk("src_ack_gating", {62'd0, dst_rdy, ~src_rdy}, 64'd0);
            if (src_rdy && src_ack) begin
                void'(src_q.pop_front());
                words_taken++;
                holding = 1'b0;
            end else begin
                holding = src_rdy;
            end
        end
    end

    // Sink: acks beats (optionally after a hold or randomly) and checks stall stability.
    initial begin
        int               waitc;
        bit               pstall;
        logic [OW-1:0]    pd;
        logic [NPACK-1:0] pm;
        logic             pl;
        waitc = 0;
        pstall = 1'b0;
        forever begin
            @(negedge i_clk);
            if (pstall && drv_en && i_rst && dst_rdy) begin
                chk("stall_data", 64'(o_data), 64'(pd));
                chk("stall_mask", 64'(o_mask), 64'(pm));
                chk("stall_last", 64'(o_last), 64'(pl));
            end
            if (drv_en && dst_rdy)
                dst_ack = (waitc >= dst_hold) &&
                          !(dst_stall_pct > 0 && $urandom_range(99) < dst_stall_pct);
            else
                dst_ack = 1'b0;
            if (dst_ack) begin
                cap_d.push_back(o_data);
                cap_m.push_back(o_mask);
                cap_l.push_back(o_last);
                waitc = 0;
                pstall = 1'b0;
            end else if (drv_en && dst_rdy) begin
                waitc++;
                pstall = 1'b1;
                pd = o_data; pm = o_mask; pl = o_last;
            end else begin
                waitc = 0;
                pstall = 1'b0;
            end
        end
    end

    task automatic do_cfg(input int len, output int waited);
        @(negedge i_clk);
        cfg_rdy   = 1'b1;
        i_cfg_len = LW'(len);
        waited    = 0;
        #1;
        while (!cfg_ack && waited < 2000) begin
            @(negedge i_clk);
            #1;
            waited++;
        end
        chk("cfg_accept", 64'(cfg_ack), 64'd1);
        @(negedge i_clk);
        cfg_rdy = 1'b0;
    endtask

    task automatic wait_beats(input string name, input int n, input int budget);
        int c;
        c = 0;
        while (cap_d.size() < n && c < budget) begin
            @(negedge i_clk);
            c++;
        end
        repeat (6) @(negedge i_clk);
        chk(name, 64'(cap_d.size()), 64'(n));
    endtask

    task automatic compare_all(input string name);
        chk({name, "_beats"}, 64'(cap_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
            chk({name, "_data"}, 64'(cap_d[i]), 64'(exp_d[i]));
            chk({name, "_mask"}, 64'(cap_m[i]), 64'(exp_m[i]));
            chk({name, "_last"}, 64'(cap_l[i]), 64'(exp_l[i]));
        end
        clear_caps();
    endtask

    typedef struct {
        int               len;
        int               w0;
        int               step;
        int               nbeats;
        logic [OW-1:0]    d_first;
        logic [NPACK-1:0] m_first;
        logic             l_first;
        logic [OW-1:0]    d_last;
        logic [NPACK-1:0] m_last;
        logic             l_last;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            waited;
        int            base;
        int            c;
        int            nlast;
        logic [BW-1:0] w[$];

        tbl[0] = '{4, 'h11, 'h11, 1, 32'h44332211, 4'b1111, 1'b1, 32'h44332211, 4'b1111, 1'b1};
        tbl[1] = '{6, 'h01, 'h01, 2, 32'h04030201, 4'b1111, 1'b0, 32'h00000605, 4'b0011, 1'b1};
        tbl[2] = '{1, 'hAB, 'h00, 1, 32'h000000AB, 4'b0001, 1'b1, 32'h000000AB, 4'b0001, 1'b1};
        tbl[3] = '{7, 'hF0, 'h03, 2, 32'hF9F6F3F0, 4'b1111, 1'b0, 32'h00FFFCFC - 32'h00000000 + 32'h0, 4'b0111, 1'b1};
        // 7 words from 0xF0 step 3: F0 F3 F6 F9 | FC FF 02 -> second beat 0x0002FFFC.
        tbl[3].d_last = 32'h0002FFFC;

        // Reset state.
        #3 i_rst = 1'b0;
        @(negedge i_clk);
        src_rdy = 1'b1;
        #1;
        chk("rst_dst_rdy", 64'(dst_rdy), 64'd0);
        chk("rst_data",    64'(o_data),  64'd0);
        chk("rst_mask",    64'(o_mask),  64'd0);
        chk("rst_last",    64'(o_last),  64'd0);
        chk("rst_src_ack", 64'(src_ack), 64'd0);
        src_rdy = 1'b0;
        @(negedge i_clk);
        i_rst  = 1'b1;
        drv_en = 1'b1;

        // Zero-length descriptor is taken in one cycle and produces nothing.
        do_cfg(0, waited);
        chk("len0_ack_wait", 64'(waited), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            chk("len0_dst_rdy", 64'(dst_rdy), 64'd0);
        end
        chk("len0_beats", 64'(cap_d.size()), 64'd0);

        // Table-driven packets.
        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < tbl[t].len; j++) src_q.push_back(BW'(tbl[t].w0 + j * tbl[t].step));
            do_cfg(tbl[t].len, waited);
            wait_beats("tbl_beats", tbl[t].nbeats, 500);
            if (cap_d.size() > 0) begin
                chk("tbl_first_data", 64'(cap_d[0]), 64'(tbl[t].d_first));
                chk("tbl_first_mask", 64'(cap_m[0]), 64'(tbl[t].m_first));
                chk("tbl_first_last", 64'(cap_l[0]), 64'(tbl[t].l_first));
                chk("tbl_final_data", 64'(cap_d[cap_d.size()-1]), 64'(tbl[t].d_last));
                chk("tbl_final_mask", 64'(cap_m[cap_m.size()-1]), 64'(tbl[t].m_last));
                chk("tbl_final_last", 64'(cap_l[cap_l.size()-1]), 64'(tbl[t].l_last));
            end
            clear_caps();
        end

        // Stalls: toggling source and a 3-cycle sink hold.
        w.delete();
        for (int j = 0; j < 5; j++) w.push_back(BW'(8'h50 + j));
        model_packet(w);
        foreach (w[j]) src_q.push_back(w[j]);
        src_toggle = 1'b1;
        dst_hold   = 3;
        do_cfg(5, waited);
        wait_beats("stall_beats", 2, 500);
        compare_all("stall");
        src_toggle = 1'b0;
        dst_hold   = 0;

        // Reset in the middle of a packet.
        for (int j = 0; j < 8; j++) src_q.push_back(BW'(8'hC0 + j));
        base = words_taken;
        do_cfg(8, waited);
        c = 0;
        while (words_taken - base < 3 && c < 200) begin
            @(negedge i_clk);
            #2;
            c++;
        end
        @(posedge i_clk);
        #1;
        drv_en  = 1'b0;
        i_rst   = 1'b0;
        src_rdy = 1'b1;
        #1;
        chk("mid_rst_dst_rdy", 64'(dst_rdy), 64'd0);
        chk("mid_rst_data",    64'(o_data),  64'd0);
        chk("mid_rst_mask",    64'(o_mask),  64'd0);
        chk("mid_rst_last",    64'(o_last),  64'd0);
        chk("mid_rst_src_ack", 64'(src_ack), 64'd0);
        src_rdy = 1'b0;
        src_q.delete();
        clear_caps();
        repeat (2) @(negedge i_clk);
        i_rst  = 1'b1;
        drv_en = 1'b1;
        src_q.push_back(8'h7E);
        src_q.push_back(8'h7F);
        do_cfg(2, waited);
        wait_beats("post_rst_beats", 1, 200);
        if (cap_d.size() > 0) begin
            chk("post_rst_data", 64'(cap_d[0]), 64'h00007F7E);
            chk("post_rst_mask", 64'(cap_m[0]), 64'b0011);
            chk("post_rst_last", 64'(cap_l[0]), 64'd1);
        end
        clear_caps();

        // Maximum length packet followed immediately by a short one.
        w.delete();
        for (int j = 0; j < 255; j++) w.push_back(BW'(j));
        model_packet(w);
        foreach (w[j]) src_q.push_back(w[j]);
        w.delete();
        for (int j = 0; j < 3; j++) w.push_back(BW'(8'hA0 + j));
        model_packet(w);
        foreach (w[j]) src_q.push_back(w[j]);
        do_cfg(255, waited);
        do_cfg(3, waited);
        wait_beats("b2b_beats", 65, 3000);
        nlast = 0;
        foreach (cap_l[i]) if (cap_l[i]) nlast++;
        chk("b2b_last_count", 64'(nlast), 64'd2);
        if (cap_d.size() >= 65) begin
            chk("b2b_beat63_mask", 64'(cap_m[63]), 64'b0111);
            chk("b2b_beat63_last", 64'(cap_l[63]), 64'd1);
            chk("b2b_beat62_last", 64'(cap_l[62]), 64'd0);
        end
        compare_all("b2b");

        // Randomized packets with random stalls on both sides.
        for (int p = 0; p < 20; p++) begin
            int len;
            len = $urandom_range(0, 40);
            src_stall_pct = $urandom_range(0, 60);
            dst_stall_pct = $urandom_range(0, 60);
            w.delete();
            for (int j = 0; j < len; j++) w.push_back(BW'($urandom));
            model_packet(w);
            foreach (w[j]) src_q.push_back(w[j]);
            do_cfg(len, waited);
            wait_beats("rand_beats", exp_d.size(), 2000);
            compare_all("rand");
        end
        src_stall_pct = 0;
        dst_stall_pct = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
